// File: rtl/cpu_types_pkg.sv
// Shared pipeline-register bundle types for the 5-stage CPU.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] npc;
  } ifid_t;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic [3:0]        aluop;
    logic [WORD_W-1:0] rdat1;
    logic [WORD_W-1:0] rdat2;
    logic [WORD_W-1:0] imm;
    logic [WORD_W-1:0] npc;
  } idex_t;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic [WORD_W-1:0] alu_out;
    logic [WORD_W-1:0] store_data;
  } exmem_t;

  // Destination reported to the hazard unit: zero when the stage writes nothing.
  function automatic logic [REG_W-1:0] fwd_dest(input logic valid, input logic regwrite,
                                                input logic [REG_W-1:0] dest);
    return (valid && regwrite) ? dest : '0;
  endfunction

endpackage

// File: rtl/pipe_latch.sv
// One pipeline register with a valid bit. Priority: flush > hold > bubble > load;
// with nothing asserted the register keeps its contents.
module pipe_latch #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         flush,
  input  logic         hold,
  input  logic         bubble,
  input  logic         load,
  input  logic         valid_in,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  // Register update; a bubble is an all-zero payload with valid cleared.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (hold) begin
      q     <= q;
      valid <= valid;
    end else if (bubble) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= valid_in;
    end
  end

endmodule

// File: rtl/pipeline_latch_ctrl.sv
// IF/ID, ID/EX and EX/MEM registers with stall/flush/freeze control,
// hazard feedback and saturating bubble/freeze performance counters.
module pipeline_latch_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             fetch_stall,
  input  logic             fetch_flush,
  input  logic             decode_stall,
  input  logic             decode_flush,
  input  logic             execute_flush,
  input  ifid_t            if_in,
  input  idex_t            id_in,
  input  exmem_t           ex_in,
  output ifid_t            ifid_out,
  output logic             ifid_valid,
  output idex_t            idex_out,
  output logic             idex_valid,
  output exmem_t           exmem_out,
  output logic             exmem_valid,
  output logic             pc_en,
  output logic [REG_W-1:0] execDest,
  output logic             MemRead_Ex,
  output logic [REG_W-1:0] memDest,
  output logic             MemRead_Mem,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  logic freeze;
  logic bubble_inc;

  // Freeze, PC enable and hazard feedback are all combinational on current latch state.
  always_comb begin
    freeze      = exmem_valid & (exmem_out.memread | exmem_out.memwrite) & ~dhit;
    pc_en       = (ihit & ~fetch_stall & ~freeze & ~fetch_flush) | fetch_flush;
    bubble_inc  = decode_flush | (~freeze & decode_stall);
    execDest    = fwd_dest(idex_valid, idex_out.regwrite, idex_out.dest);
    MemRead_Ex  = idex_valid & idex_out.memread;
    memDest     = fwd_dest(exmem_valid, exmem_out.regwrite, exmem_out.dest);
    MemRead_Mem = exmem_valid & exmem_out.memread;
  end

  pipe_latch #(.W($bits(ifid_t))) u_ifid (
    .clk      (CLK),
    .nrst     (nRST),
    .flush    (fetch_flush),
    .hold     (freeze | fetch_stall),
    .bubble   (~ihit),
    .load     (ihit),
    .valid_in (1'b1),
    .d        (if_in),
    .q        (ifid_out),
    .valid    (ifid_valid)
  );

  pipe_latch #(.W($bits(idex_t))) u_idex (
    .clk      (CLK),
    .nrst     (nRST),
    .flush    (decode_flush),
    .hold     (freeze),
    .bubble   (decode_stall),
    .load     (1'b1),
    .valid_in (ifid_valid),
    .d        (id_in),
    .q        (idex_out),
    .valid    (idex_valid)
  );

  pipe_latch #(.W($bits(exmem_t))) u_exmem (
    .clk      (CLK),
    .nrst     (nRST),
    .flush    (execute_flush),
    .hold     (freeze),
    .bubble   (1'b0),
    .load     (1'b1),
    .valid_in (idex_valid),
    .d        (ex_in),
    .q        (exmem_out),
    .valid    (exmem_valid)
  );

  // Saturating counters: a flush and a stall in the same cycle count once.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      bubble_cnt <= '0;
      freeze_cnt <= '0;
    end else begin
      if (bubble_inc && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
      if (freeze && (freeze_cnt != {CNT_W{1'b1}}))
        freeze_cnt <= freeze_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_latch_ctrl.sv
// Directed bench for pipeline_latch_ctrl with an EX/MEM scoreboard queue.
module tb_pipeline_latch_ctrl;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit = 1'b0, dhit = 1'b0;
  logic fetch_stall = 1'b0, fetch_flush = 1'b0;
  logic decode_stall = 1'b0, decode_flush = 1'b0, execute_flush = 1'b0;
  ifid_t  if_in;
  idex_t  id_in;
  exmem_t ex_in;

  ifid_t  ifid_out;
  idex_t  idex_out;
  exmem_t exmem_out;
  logic   ifid_valid, idex_valid, exmem_valid, pc_en, MemRead_Ex, MemRead_Mem;
  logic [4:0]  execDest, memDest;
  logic [15:0] bubble_cnt, freeze_cnt;

  ifid_t  s_ifid_out;
  idex_t  s_idex_out;
  exmem_t s_exmem_out;
  logic   s_ifid_valid, s_idex_valid, s_exmem_valid, s_pc_en, s_MemRead_Ex, s_MemRead_Mem;
  logic [4:0] s_execDest, s_memDest;
  logic [1:0] s_bubble_cnt, s_freeze_cnt;

  int errors = 0;
  int checks = 0;
  logic [32:0] sbq[$];
  logic [32:0] sbExp;

  pipeline_latch_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .fetch_stall(fetch_stall), .fetch_flush(fetch_flush),
    .decode_stall(decode_stall), .decode_flush(decode_flush), .execute_flush(execute_flush),
    .if_in(if_in), .id_in(id_in), .ex_in(ex_in),
    .ifid_out(ifid_out), .ifid_valid(ifid_valid),
    .idex_out(idex_out), .idex_valid(idex_valid),
    .exmem_out(exmem_out), .exmem_valid(exmem_valid),
    .pc_en(pc_en), .execDest(execDest), .MemRead_Ex(MemRead_Ex),
    .memDest(memDest), .MemRead_Mem(MemRead_Mem),
    .bubble_cnt(bubble_cnt), .freeze_cnt(freeze_cnt)
  );

  pipeline_latch_ctrl #(.CNT_W(2)) u_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .fetch_stall(fetch_stall), .fetch_flush(fetch_flush),
    .decode_stall(decode_stall), .decode_flush(decode_flush), .execute_flush(execute_flush),
    .if_in(if_in), .id_in(id_in), .ex_in(ex_in),
    .ifid_out(s_ifid_out), .ifid_valid(s_ifid_valid),
    .idex_out(s_idex_out), .idex_valid(s_idex_valid),
    .exmem_out(s_exmem_out), .exmem_valid(s_exmem_valid),
    .pc_en(s_pc_en), .execDest(s_execDest), .MemRead_Ex(s_MemRead_Ex),
    .memDest(s_memDest), .MemRead_Mem(s_MemRead_Mem),
    .bubble_cnt(s_bubble_cnt), .freeze_cnt(s_freeze_cnt)
  );

  always #5 CLK = ~CLK;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge CLK);
    #1;
  endtask

  function automatic idex_t mkId(input logic [4:0] dest, input logic memread,
                                 input logic regwrite, input logic [31:0] npc);
    idex_t v;
    v = '0;
    v.dest = dest; v.memread = memread; v.regwrite = regwrite; v.npc = npc;
    return v;
  endfunction

  function automatic exmem_t mkEx(input logic [4:0] dest, input logic memread,
                                  input logic memwrite, input logic [31:0] alu);
    exmem_t v;
    v = '0;
    v.dest = dest; v.memread = memread; v.memwrite = memwrite; v.regwrite = ~memwrite;
    v.alu_out = alu;
    return v;
  endfunction

  function automatic logic [31:0] tag(input int k);
    return 32'h1000_0000 + k;
  endfunction

  initial begin
    if_in = '0; id_in = '0; ex_in = '0;

    // Reset state
    applyStimulus(); applyStimulus();
    checkOutput("rst_ifid_valid", ifid_valid, 0);
    checkOutput("rst_idex_valid", idex_valid, 0);
    checkOutput("rst_exmem_valid", exmem_valid, 0);
    checkOutput("rst_bubble_cnt", bubble_cnt, 0);
    checkOutput("rst_freeze_cnt", freeze_cnt, 0);
    checkOutput("rst_pc_en", pc_en, 0);

    // Three loading cycles, then reset for one cycle
    nRST = 1'b1; ihit = 1'b1; dhit = 1'b1;
    if_in = '{instr: 32'h8C22_0004, npc: 32'h4};
    id_in = mkId(5'd2, 1'b1, 1'b1, 32'h4);
    ex_in = mkEx(5'd3, 1'b0, 1'b0, 32'h44);
    applyStimulus(); applyStimulus(); applyStimulus();
    checkOutput("pre_exmem_valid", exmem_valid, 1);
    checkOutput("pre_execDest", execDest, 2);
    checkOutput("pre_memDest", memDest, 3);
    nRST = 1'b0;
    applyStimulus();
    checkOutput("rst2_ifid_valid", ifid_valid, 0);
    checkOutput("rst2_idex_valid", idex_valid, 0);
    checkOutput("rst2_exmem_valid", exmem_valid, 0);
    checkOutput("rst2_ifid_out", ifid_out, 0);
    checkOutput("rst2_execDest", execDest, 0);
    checkOutput("rst2_bubble_cnt", bubble_cnt, 0);

    // Straight flow: each fetched tag reaches EX/MEM three cycles after its ihit
    nRST = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ihit = (c < 6);
      if (c < 6) begin
        if_in = '{instr: tag(c), npc: tag(c) + 4};
        sbq.push_back({1'b1, tag(c)});
      end
      id_in = mkId(5'd1, 1'b0, 1'b1, (c >= 1) ? tag(c - 1) : 32'h0);
      ex_in = mkEx(5'd5, 1'b0, 1'b0, (c >= 2) ? tag(c - 2) : 32'h0);
      #1;
      checkOutput("flow_pc_en", pc_en, {159'b0, ihit});
      applyStimulus();
      if (c >= 2) begin
        if (sbq.size() == 0) begin
          checkOutput("flow_sb_underflow", 1, 0);
        end else begin
          sbExp = sbq.pop_front();
          checkOutput("flow_exmem", {exmem_valid, exmem_out.alu_out}, sbExp);
        end
      end
    end
    checkOutput("flow_sb_empty", sbq.size(), 0);

    // Load-use stall: lw in ID/EX, stall fetch and decode for one cycle
    ihit = 1'b1;
    if_in = '{instr: 32'hAAAA_0001, npc: 32'h100};
    id_in = mkId(5'd7, 1'b0, 1'b1, 32'h0);
    ex_in = mkEx(5'd4, 1'b0, 1'b0, 32'h11);
    applyStimulus();
    if_in = '{instr: 32'hAAAA_0002, npc: 32'h104};
    id_in = mkId(5'd2, 1'b1, 1'b1, 32'h100);
    applyStimulus();
    fetch_stall = 1'b1; decode_stall = 1'b1;
    if_in = '{instr: 32'hAAAA_0003, npc: 32'h108};
    #1;
    checkOutput("stall_MemRead_Ex", MemRead_Ex, 1);
    checkOutput("stall_execDest", execDest, 2);
    checkOutput("stall_pc_en", pc_en, 0);
    applyStimulus();
    fetch_stall = 1'b0; decode_stall = 1'b0;
    checkOutput("stall_ifid_held", ifid_out.instr, 32'hAAAA_0002);
    checkOutput("stall_idex_valid", idex_valid, 0);
    checkOutput("stall_idex_out", idex_out, 0);
    checkOutput("stall_bubble_cnt", bubble_cnt, 1);
    checkOutput("stall_exmem_valid", exmem_valid, 1);

    // Memory freeze: sw in EX/MEM, dhit low for four cycles
    dhit = 1'b0;
    if_in = '{instr: 32'hBBBB_0001, npc: 32'h200};
    id_in = mkId(5'd8, 1'b0, 1'b1, 32'h104);
    ex_in = mkEx(5'd0, 1'b0, 1'b1, 32'h5555);
    applyStimulus();
    if_in = '{instr: 32'hBBBB_0002, npc: 32'h204};
    id_in = mkId(5'd9, 1'b0, 1'b1, 32'h200);
    applyStimulus();
    checkOutput("frz_exmem_sw", {exmem_valid, exmem_out.memwrite}, 2'b11);
    for (int i = 0; i < 4; i++) begin
      if_in = '{instr: 32'hCCCC_0000 + i, npc: 32'h300};
      id_in = mkId(5'd10, 1'b0, 1'b1, 32'h300 + i);
      ex_in = mkEx(5'd11, 1'b0, 1'b0, 32'h6666);
      #1;
      checkOutput("frz_pc_en", pc_en, 0);
      applyStimulus();
      checkOutput("frz_ifid_hold", ifid_out.instr, 32'hBBBB_0002);
      checkOutput("frz_idex_hold", idex_out.npc, 32'h200);
      checkOutput("frz_exmem_hold", exmem_out.alu_out, 32'h5555);
    end
    checkOutput("frz_freeze_cnt", freeze_cnt, 4);
    dhit = 1'b1;
    if_in = '{instr: 32'hDDDD_0001, npc: 32'h400};
    id_in = mkId(5'd12, 1'b0, 1'b1, 32'h400);
    ex_in = mkEx(5'd13, 1'b0, 1'b0, 32'h7777);
    #1;
    checkOutput("frz_release_pc_en", pc_en, 1);
    applyStimulus();
    checkOutput("frz_release_exmem", {exmem_valid, exmem_out.alu_out}, {1'b1, 32'h7777});
    checkOutput("frz_release_idex", idex_out.npc, 32'h400);
    checkOutput("frz_release_ifid", ifid_out.instr, 32'hDDDD_0001);
    checkOutput("frz_release_cnt", freeze_cnt, 4);

    // Flush priority: fetch_flush with fetch_stall while frozen on a load
    dhit = 1'b0;
    ex_in = mkEx(5'd14, 1'b1, 1'b0, 32'h8888);
    applyStimulus();
    checkOutput("flush_memDest", {MemRead_Mem, memDest}, {1'b1, 5'd14});
    fetch_flush = 1'b1; fetch_stall = 1'b1;
    #1;
    checkOutput("flush_pc_en", pc_en, 1);
    applyStimulus();
    checkOutput("flush_ifid_valid", ifid_valid, 0);
    checkOutput("flush_ifid_out", ifid_out, 0);
    checkOutput("flush_exmem_hold", exmem_out.alu_out, 32'h8888);
    checkOutput("flush_freeze_cnt", freeze_cnt, 5);
    fetch_flush = 1'b0; fetch_stall = 1'b0; dhit = 1'b1; ihit = 1'b0;
    applyStimulus();

    // Saturation: 2-bit counter under six cycles of decode_flush
    nRST = 1'b0;
    applyStimulus();
    nRST = 1'b1; decode_flush = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus();
      checkOutput("sat_bubble_cnt", s_bubble_cnt, (i > 3) ? 3 : i);
    end
    checkOutput("sat_wide_bubble_cnt", bubble_cnt, 6);
    decode_flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
